// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared widths and the buffered MCU result entry type
package rv_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/rf_result_fifo.sv
// rtl/rf_result_fifo.sv - synchronous FIFO buffering MCU results until the write port is free
module rf_result_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fifo_entry_t              push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output fifo_entry_t              head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == (PW+1)'(DEPTH));
        empty    = (count_q == '0);
        head     = mem_q[rd_ptr_q];
        count    = count_q;
        do_pop   = pop && !empty;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter, busy scoreboard and starvation monitor
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mc_issue,
    input  logic [AW-1:0]   mc_issue_rd,
    input  logic            mc_valid,
    input  logic [AW-1:0]   mc_rd,
    input  logic [XLEN-1:0] mc_data,
    output logic            mc_ready,
    input  logic [AW-1:0]   dec_rs1,
    input  logic [AW-1:0]   dec_rs2,
    input  logic [AW-1:0]   dec_rd,
    output logic            dec_stall,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic            drain_req,
    output logic            err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic            fifo_full, fifo_empty;
    fifo_entry_t     fifo_head, fifo_in;
    logic [CW-1:0]   fifo_count;
    logic            pipe_active, fifo_pop, mc_accept, fifo_push;
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;
    logic [SW-1:0]   starve_q, starve_d;

    rf_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        // Port outputs are combinational, so they are also forced idle while reset is held.
        pipe_active  = rst_n && wb_valid && (wb_rd != REG_ZERO);
        fifo_pop     = rst_n && !pipe_active && !fifo_empty;
        mc_accept    = mc_valid && (!fifo_full || fifo_pop);
        fifo_push    = mc_accept && (mc_rd != REG_ZERO);
        fifo_in.rd   = mc_rd;
        fifo_in.data = mc_data;

        rf_we = pipe_active || fifo_pop;
        rf_a3 = '0;
        rf_wd = '0;
        if (pipe_active) begin
            rf_a3 = wb_rd;
            rf_wd = wb_data;
        end else if (fifo_pop) begin
            rf_a3 = fifo_head.rd;
            rf_wd = fifo_head.data;
        end

        // Clear first so a same-cycle re-issue of the retiring rd keeps it busy.
        busy_d = busy_q;
        if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
        if (mc_issue) busy_d[mc_issue_rd]  = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q
              || (mc_issue && busy_q[mc_issue_rd])
              || (mc_valid && !mc_accept)
              || (mc_valid && (mc_rd != REG_ZERO) && !busy_q[mc_rd]);

        starve_d = starve_q;
        if (fifo_empty || fifo_pop) starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);

        mc_ready  = (fifo_count != CW'(FIFO_DEPTH));
        dec_stall = busy_q[dec_rs1] || busy_q[dec_rs2] || busy_q[dec_rd];
        drain_req = (starve_q == SW'(STARVE_MAX));
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            err_q    <= err_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    import rv_pkg::*;

    logic            clk, rst_n;
    logic            wb_valid, mc_issue, mc_valid;
    logic [AW-1:0]   wb_rd, mc_issue_rd, mc_rd, dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0] wb_data, mc_data;
    logic            mc_ready, dec_stall, rf_we, drain_req, err;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd;

    typedef struct packed {
        logic [AW-1:0]   a3;
        logic [XLEN-1:0] wd;
    } wr_t;

    typedef struct {
        logic            wv;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            ewe;
        logic [AW-1:0]   ea3;
        logic [XLEN-1:0] ewd;
    } vec_t;

    wr_t  sb_q[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_fail = 0;

    rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .drain_req(drain_req), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got a3=%0d wd=%h expected no write at %0t", rf_a3, rf_wd, $time);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("sb_a3", 32'(rf_a3), 32'(e.a3));
                check("sb_wd", rf_wd, e.wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mc_issue = 0; mc_issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a3, input logic [XLEN-1:0] wd);
        wr_t e;
        e.a3 = a3;
        e.wd = wd;
        sb_q.push_back(e);
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        wb_valid = 1; wb_rd = rd; wb_data = data;
        expect_wr(rd, data);
    endtask

    task automatic mc(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        mc_valid = 1; mc_rd = rd; mc_data = data;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        step(); idle();
        mc_issue = 1; mc_issue_rd = rd;
    endtask

    task automatic do_reset();
        step(); idle(); rst_n = 0;
        step(); rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        vecs[0] = '{1'b1, 5'd3,  32'h0000_000C, 1'b1, 5'd3,  32'h0000_000C};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_0055, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b0, 5'd7,  32'h0000_0077, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 5'd1,  32'h0000_1234, 1'b1, 5'd1,  32'h0000_1234};

        repeat (2) @(posedge clk);
        #1;
        check("rst_mc_ready", 32'(mc_ready), 1);
        check("rst_dec_stall", 32'(dec_stall), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_drain_req", 32'(drain_req), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1;

        // Pipeline-only vectors
        for (int i = 0; i < 5; i++) begin
            step(); idle();
            wb_valid = vecs[i].wv; wb_rd = vecs[i].rd; wb_data = vecs[i].data;
            if (vecs[i].ewe) expect_wr(vecs[i].ea3, vecs[i].ewd);
            at_neg();
            check("vec_rf_we", 32'(rf_we), 32'(vecs[i].ewe));
            check("vec_rf_a3", 32'(rf_a3), 32'(vecs[i].ea3));
            check("vec_rf_wd", rf_wd, vecs[i].ewd);
        end

        // MCU round trip
        issue(5'd8); dec_rs1 = 8;
        at_neg(); check("rt_no_bypass", 32'(dec_stall), 0);
        step(); idle(); dec_rs1 = 8; mc(5'd8, 32'h1E);
        at_neg(); check("rt_stall", 32'(dec_stall), 1); check("rt_idle_we", 32'(rf_we), 0);
        step(); idle(); dec_rs1 = 8; expect_wr(5'd8, 32'h1E);
        at_neg(); check("rt_write_we", 32'(rf_we), 1); check("rt_stall_hold", 32'(dec_stall), 1);
        step(); idle(); dec_rs1 = 8;
        at_neg(); check("rt_stall_drop", 32'(dec_stall), 0); check("rt_err", 32'(err), 0);

        // Contention and starvation
        issue(5'd6);
        issue(5'd7);
        step(); idle(); wb(5'd5, 32'h500); mc(5'd6, 32'h66);
        step(); idle(); wb(5'd5, 32'h501); mc(5'd7, 32'h77);
        at_neg(); check("ct_ready_one", 32'(mc_ready), 1);
        for (int k = 2; k <= 8; k++) begin
            step(); idle(); wb(5'd5, 32'h500 + 32'(k));
            at_neg();
            if (k == 2) check("ct_ready_full", 32'(mc_ready), 0);
            if (k == 8) check("ct_drain_early", 32'(drain_req), 0);
        end
        step(); idle(); wb(5'd5, 32'h509);
        at_neg(); check("ct_drain_rise", 32'(drain_req), 1);
        step(); idle(); wb(5'd5, 32'h50A); dec_rs1 = 6;
        at_neg(); check("ct_drain_sat", 32'(drain_req), 1); check("ct_stall6", 32'(dec_stall), 1);
        step(); idle(); expect_wr(5'd6, 32'h66);
        at_neg(); check("ct_bubble_drain", 32'(drain_req), 1);
        step(); idle(); wb(5'd5, 32'h50B); dec_rd = 6;
        at_neg(); check("ct_drain_clr", 32'(drain_req), 0); check("ct_stall6_clr", 32'(dec_stall), 0);
        check("ct_ready_back", 32'(mc_ready), 1);
        step(); idle(); wb(5'd5, 32'h50C); dec_rs2 = 7;
        at_neg(); check("ct_stall7", 32'(dec_stall), 1);
        step(); idle(); expect_wr(5'd7, 32'h77);
        step(); idle();
        at_neg(); check("ct_idle_we", 32'(rf_we), 0); check("ct_err", 32'(err), 0);

        // Full FIFO with simultaneous push and pop
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        step(); idle(); wb(5'd5, 32'h600); mc(5'd10, 32'hA0);
        step(); idle(); wb(5'd5, 32'h601); mc(5'd11, 32'hB0);
        step(); idle(); mc(5'd12, 32'hC0); expect_wr(5'd10, 32'hA0);
        at_neg(); check("fp_ready_full", 32'(mc_ready), 0);
        step(); idle(); expect_wr(5'd11, 32'hB0);
        at_neg(); check("fp_count_kept", 32'(mc_ready), 0);
        step(); idle(); expect_wr(5'd12, 32'hC0);
        at_neg(); check("fp_ready_one", 32'(mc_ready), 1);
        step(); idle();
        at_neg(); check("fp_no_err", 32'(err), 0);

        // Push while full with the port owned by the pipeline: dropped, err
        issue(5'd13);
        issue(5'd14);
        issue(5'd15);
        step(); idle(); wb(5'd5, 32'h700); mc(5'd13, 32'hD0);
        step(); idle(); wb(5'd5, 32'h701); mc(5'd14, 32'hE0);
        step(); idle(); wb(5'd5, 32'h702); mc(5'd15, 32'hF0);
        at_neg(); check("er_ready_full", 32'(mc_ready), 0); check("er_not_yet", 32'(err), 0);
        step(); idle(); wb(5'd5, 32'h703);
        at_neg(); check("er_drop_err", 32'(err), 1);
        step(); idle(); expect_wr(5'd13, 32'hD0);
        step(); idle(); expect_wr(5'd14, 32'hE0);
        step(); idle();
        step(); idle();
        at_neg(); check("er_no_stale", 32'(rf_we), 0); check("er_sticky", 32'(err), 1);

        // Double issue
        do_reset();
        at_neg(); check("di_err_clr", 32'(err), 0);
        issue(5'd4);
        issue(5'd4);
        at_neg(); check("di_err_pre", 32'(err), 0);
        step(); idle();
        at_neg(); check("di_err_set", 32'(err), 1);
        step(); idle();
        step(); idle();
        at_neg(); check("di_err_sticky", 32'(err), 1);
        do_reset();

        // Asynchronous reset mid-operation
        issue(5'd9);
        issue(5'd16);
        step(); idle(); wb(5'd5, 32'h800); mc(5'd9, 32'h90);
        step(); idle(); wb(5'd5, 32'h801); mc(5'd16, 32'hA6);
        step(); idle(); wb(5'd5, 32'h802); mc(5'd9, 32'h91);
        at_neg(); check("ar_ready_full", 32'(mc_ready), 0);
        step(); idle(); wb(5'd5, 32'h803); dec_rs1 = 9;
        at_neg(); check("ar_err_pre", 32'(err), 1); check("ar_stall_pre", 32'(dec_stall), 1);
        step(); idle(); dec_rs1 = 9; rst_n = 0;
        #1;
        check("ar_mc_ready", 32'(mc_ready), 1);
        check("ar_dec_stall", 32'(dec_stall), 0);
        check("ar_rf_we", 32'(rf_we), 0);
        check("ar_rf_a3", 32'(rf_a3), 0);
        check("ar_rf_wd", rf_wd, 0);
        check("ar_drain_req", 32'(drain_req), 0);
        check("ar_err", 32'(err), 0);
        step(); rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step(); idle();
            at_neg(); check("ar_no_stale", 32'(rf_we), 0);
        end

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
